// File: rtl/stream_serializer.sv
// stream_serializer: wide-to-narrow stream transmitter, least-significant beat first.
// A one-item pending buffer keeps i_ready a plain register output without bubbles.
module stream_serializer #(
    parameter int W = 8,
    parameter int K = 4
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           clk_en,
    input  logic           i_valid,
    output logic           i_ready,
    input  logic [W*K-1:0] i,
    output logic           o_valid,
    input  logic           o_ready,
    output logic [W-1:0]   o,
    output logic           o_last
);
    localparam int CW = (K > 1) ? $clog2(K) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(K - 1);

    logic [W*K-1:0] sh;
    logic [W*K-1:0] pend;
    logic [CW-1:0]  cnt;
    logic           pend_valid;
    logic           enq;
    logic           beat;
    logic           frees;

    assign i_ready = ~pend_valid;
    assign o       = sh[W-1:0];
    assign o_last  = o_valid && (cnt == CNT_LAST);

    // frees: the shift register is empty or its last beat leaves this cycle
    always_comb begin
        enq   = clk_en && i_valid && i_ready;
        beat  = clk_en && o_valid && o_ready;
        frees = clk_en && (!o_valid || (beat && o_last));
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sh         <= '0;
            pend       <= '0;
            cnt        <= '0;
            pend_valid <= 1'b0;
            o_valid    <= 1'b0;
        end else begin
            if (frees && pend_valid) begin
                sh         <= pend;
                cnt        <= '0;
                o_valid    <= 1'b1;
                pend_valid <= 1'b0;
            end else if (frees && enq) begin
                sh      <= i;
                cnt     <= '0;
                o_valid <= 1'b1;
            end else if (frees) begin
                o_valid <= 1'b0;
            end else if (beat) begin
                sh  <= sh >> W;
                cnt <= cnt + 1'b1;
            end
            // pend_valid is never set here while it is also being cleared above
            if (enq && !frees) begin
                pend       <= i;
                pend_valid <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_stream_serializer.sv
// Bench for stream_serializer: a K=4 and a K=1 instance checked every cycle against
// an item-queue model, plus directed sequences with literal expected beats.
module tb_stream_serializer;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        ce = 1'b1;
    logic        iv[2];
    logic        ordy[2];
    logic [31:0] id[2];
    logic        ir[2];
    logic        ov[2];
    logic        ol[2];
    logic [7:0]  od[2];

    int checks = 0;
    int errors = 0;

    // Model: each instance holds at most two items; head item emits beats in order.
    logic [31:0] mitem[2][2];
    int          mcnt[2] = '{0, 0};
    int          midx[2] = '{0, 0};
    int          KK[2] = '{4, 1};
    logic [31:0] MASK[2] = '{32'hffff_ffff, 32'h0000_00ff};
    bit          m_enq;
    bit          m_beat;

    always #5 clk = ~clk;

    stream_serializer #(.W(8), .K(4)) u_k4 (
        .clk(clk), .rst(rst), .clk_en(ce),
        .i_valid(iv[0]), .i_ready(ir[0]), .i(id[0]),
        .o_valid(ov[0]), .o_ready(ordy[0]), .o(od[0]), .o_last(ol[0])
    );

    stream_serializer #(.W(8), .K(1)) u_k1 (
        .clk(clk), .rst(rst), .clk_en(ce),
        .i_valid(iv[1]), .i_ready(ir[1]), .i(id[1][7:0]),
        .o_valid(ov[1]), .o_ready(ordy[1]), .o(od[1]), .o_last(ol[1])
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h at %0t", nm, act, exp, $time);
        end
    endtask

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int d = 0; d < 2; d++) begin
                mcnt[d] = 0;
                midx[d] = 0;
            end
        end else if (ce) begin
            for (int d = 0; d < 2; d++) begin
                m_enq  = iv[d] && (mcnt[d] < 2);
                m_beat = (mcnt[d] > 0) && ordy[d];
                if (m_beat) begin
                    if (midx[d] == KK[d] - 1) begin
                        mitem[d][0] = mitem[d][1];
                        mcnt[d]--;
                        midx[d] = 0;
                    end else begin
                        midx[d]++;
                    end
                end
                if (m_enq) begin
                    mitem[d][mcnt[d]] = id[d] & MASK[d];
                    mcnt[d]++;
                end
            end
        end
    end

    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("cmp_valid%0d", d), 32'(ov[d]), 32'(mcnt[d] > 0));
            chk($sformatf("cmp_ready%0d", d), 32'(ir[d]), 32'(mcnt[d] < 2));
            if (mcnt[d] > 0) begin
                chk($sformatf("cmp_data%0d", d), 32'(od[d]),
                    (mitem[d][0] >> (8 * midx[d])) & 32'hff);
                chk($sformatf("cmp_last%0d", d), 32'(ol[d]), 32'(midx[d] == KK[d] - 1));
            end
        end
    end

    task automatic drain();
        iv[0] = 1'b0;
        iv[1] = 1'b0;
        ordy[0] = 1'b1;
        ordy[1] = 1'b1;
        ce = 1'b1;
        for (int n = 0; n < 100 && (mcnt[0] > 0 || mcnt[1] > 0); n++) @(negedge clk);
        chk("drain_timeout", 32'(mcnt[0] + mcnt[1]), 32'd0);
    endtask

    logic [7:0] e1[4] = '{8'h11, 8'h22, 8'h33, 8'h44};
    logic       rdy_pat[8] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    logic       k1_pat[8] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    logic [7:0] k1_log[16];
    int         nlog;
    int         nsent;
    bit         acc;

    initial begin
        for (int d = 0; d < 2; d++) begin
            iv[d] = 1'b0;
            ordy[d] = 1'b0;
            id[d] = '0;
        end
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);

        // single item, o_ready held high
        iv[0] = 1'b1; id[0] = 32'h4433_2211; ordy[0] = 1'b1;
        @(negedge clk);
        iv[0] = 1'b0;
        for (int k = 0; k < 4; k++) begin
            chk("t1_beat", 32'(od[0]), 32'(e1[k]));
            chk("t1_valid", 32'(ov[0]), 32'd1);
            chk("t1_last", 32'(ol[0]), 32'(k == 3));
            @(negedge clk);
        end
        chk("t1_idle", 32'(ov[0]), 32'd0);

        // back-to-back items, no bubble
        iv[0] = 1'b1; id[0] = 32'h0403_0201;
        @(negedge clk);
        id[0] = 32'h0807_0605;
        for (int k = 0; k < 8; k++) begin
            if (k == 1) iv[0] = 1'b0;
            chk("b2b_beat", 32'(od[0]), 32'(k + 1));
            chk("b2b_ready", 32'(ir[0]), 32'(rdy_pat[k]));
            @(negedge clk);
        end
        chk("b2b_idle", 32'(ov[0]), 32'd0);

        // backpressure at beat 0x22
        iv[0] = 1'b1; id[0] = 32'h4433_2211;
        @(negedge clk);
        iv[0] = 1'b0;
        chk("bp_b0", 32'(od[0]), 32'h11);
        @(negedge clk);
        chk("bp_b1", 32'(od[0]), 32'h22);
        ordy[0] = 1'b0;
        repeat (3) begin
            @(negedge clk);
            chk("bp_hold_o", 32'(od[0]), 32'h22);
            chk("bp_hold_v", 32'(ov[0]), 32'd1);
            chk("bp_hold_l", 32'(ol[0]), 32'd0);
        end
        ordy[0] = 1'b1;
        @(negedge clk);
        chk("bp_b2", 32'(od[0]), 32'h33);
        @(negedge clk);
        chk("bp_b3", 32'(od[0]), 32'h44);
        chk("bp_b3_last", 32'(ol[0]), 32'd1);
        @(negedge clk);
        chk("bp_idle", 32'(ov[0]), 32'd0);

        // clk_en low for two cycles mid-item
        iv[0] = 1'b1; id[0] = 32'h4433_2211;
        @(negedge clk);
        iv[0] = 1'b0;
        @(negedge clk);
        chk("ce_b1", 32'(od[0]), 32'h22);
        ce = 1'b0; iv[0] = 1'b1; id[0] = 32'hcafe_f00d;
        repeat (2) begin
            @(negedge clk);
            chk("ce_hold_o", 32'(od[0]), 32'h22);
            chk("ce_hold_v", 32'(ov[0]), 32'd1);
            chk("ce_no_acc", 32'(ir[0]), 32'd1);
        end
        ce = 1'b1;
        @(negedge clk);
        iv[0] = 1'b0;
        chk("ce_resume", 32'(od[0]), 32'h33);
        chk("ce_parked", 32'(ir[0]), 32'd0);
        drain();

        // K=1 ordering under a fixed o_ready pattern
        nsent = 0; nlog = 0; acc = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (acc) nsent++;
            iv[1] = (nsent < 8);
            id[1] = 32'(8'hA0 + nsent);
            ordy[1] = k1_pat[c % 8];
            if (ov[1] && ordy[1] && nlog < 16) begin
                k1_log[nlog] = od[1];
                nlog++;
            end
            acc = iv[1] && ir[1];
        end
        chk("k1_count", 32'(nlog), 32'd8);
        for (int j = 0; j < 8; j++) chk("k1_order", 32'(k1_log[j]), 32'(8'hA0 + j));
        drain();

        // random traffic, then asynchronous reset mid-stream
        for (int c = 0; c < 500; c++) begin
            @(negedge clk);
            ce = ($urandom_range(0, 9) != 0);
            for (int d = 0; d < 2; d++) begin
                iv[d] = ($urandom_range(0, 3) != 0);
                id[d] = $urandom;
                ordy[d] = ($urandom_range(0, 9) < 7);
            end
        end
        #2 rst = 1'b0;
        #1;
        for (int d = 0; d < 2; d++) begin
            chk("rst_valid", 32'(ov[d]), 32'd0);
            chk("rst_last", 32'(ol[d]), 32'd0);
            chk("rst_data", 32'(od[d]), 32'd0);
            chk("rst_ready", 32'(ir[d]), 32'd1);
        end
        repeat (3) begin
            @(negedge clk);
            for (int d = 0; d < 2; d++) chk("rst_hold_data", 32'(od[d]), 32'd0);
        end
        rst = 1'b1;
        for (int c = 0; c < 2500; c++) begin
            @(negedge clk);
            ce = ($urandom_range(0, 9) != 0);
            for (int d = 0; d < 2; d++) begin
                iv[d] = ($urandom_range(0, 3) != 0);
                id[d] = $urandom;
                ordy[d] = ($urandom_range(0, 9) < 7);
            end
        end
        drain();
        @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/stream_serializer.md
# stream_serializer

Wide-to-narrow stream transmitter. It accepts one K×W-bit item per valid-ready handshake and emits it as K W-bit beats, least-significant beat first, with a last-beat flag. It is the sending end that feeds narrow links and narrow `queue` instances from wide producers. `i_ready` is a direct register output, so it has no combinational path from `o_ready`; a one-item pending buffer keeps beats flowing without bubbles.

## Interface
Parameters:
- `W`, default 8: beat width in bits; must be ≥1.
- `K`, default 4: beats per item; must be ≥1. Item width is W*K.

Ports:
- `clk`  in  1  sole clock; all state changes on posedge.
- `rst`  in  1  reset, asynchronous, active-low.
- `clk_en`  in  1  when low, all state holds and no handshake completes.
- `i_valid`  in  1  input item valid.
- `i_ready`  out  1  input ready; register output, equal to !pend_valid.
- `i`  in  W*K  input item; beat n is `i[n*W +: W]`.
- `o_valid`  out  1  output beat valid; register output.
- `o_ready`  in  1  output beat accepted.
- `o`  out  W  current beat; register output.
- `o_last`  out  1  high when `o_valid` is high and the current beat is beat K-1; decoded from registers only.

## Operation
- State:
  - shift register `sh` (W*K bits);
  - beat counter `cnt` (0..K-1, `$clog2(K)` bits, min 1);
  - pending item `pend` (W*K bits) and its flag `pend_valid`;
  - `o_valid`.
- Outputs: `o = sh[W-1:0]`; `o_last = o_valid && cnt == K-1`.
- Per-cycle terms (only when `clk_en` is high):
  - `enq = i_valid && i_ready`
  - `beat = o_valid && o_ready`
  - `frees = !o_valid || (beat && o_last)`
- Update rules:
  - If `frees` and `pend_valid`: `sh <= pend`, `cnt <= 0`, `o_valid <= 1`, `pend_valid <= 0`. `enq` is impossible in this case.
  - Else if `frees` and `enq`: `sh <= i`, `cnt <= 0`, `o_valid <= 1`.
  - Else if `frees`: `o_valid <= 0`.
  - Else if `beat`: `sh <= sh >> W`, `cnt <= cnt + 1`.
  - If `enq` and not `frees`: `pend <= i`, `pend_valid <= 1`.
- The input item is captured on the `enq` edge; `i` is don't-care at all other times.
- K=1: every beat is last; the block behaves as a 2-entry stream buffer with registered ready.

## Timing
- Reset, asynchronous on `rst` falling:
  - `o_valid=0`, `o_last=0`, `o=0`, `i_ready=1`;
  - `cnt=0`, `pend_valid=0`, `sh=0`, `pend=0`.
- Reset mid-item discards the in-flight and pending items. After release, the next output beat is beat 0 of a newly accepted item.
- Latency: the first beat is valid in the cycle after the `enq` edge when the shift register is free.
- Throughput:
  - one beat per cycle while `o_ready=1`;
  - back-to-back items with `i_valid` held produce no bubble between the last beat of item n and beat 0 of item n+1.
- Handshake rules:
  - While `o_valid=1` and `o_ready=0`, `o`, `o_last` and `o_valid` hold stable.
  - `o_valid` never drops without a completed last beat, except by reset.
- `i_ready` falls the cycle after an item is parked in `pend`. It rises the cycle after `pend` moves to `sh`.
- Simultaneous last-beat and input: the item loads directly into `sh`; `pend` is not used.
- `clk_en=0` on a cycle: that cycle counts as no transfer on either side.

## Test plan
- Reset: drive `rst=0` mid-stream -> `o_valid=0`, `o_last=0`, `o=0`, `i_ready=1` immediately (before the next edge), and they stay so until release.
- W=8, K=4, one item `0x44332211`, `o_ready=1` -> beats 0x11, 0x22, 0x33, 0x44 on 4 consecutive cycles starting 1 cycle after accept; `o_last=1` only on 0x44; then `o_valid=0`.
- Back-to-back `0x04030201` then `0x08070605`, `i_valid` held, `o_ready=1` -> 8 consecutive beats 01..08 with no gap; `i_ready` low from the cycle after B is accepted until the cycle after beat 04.
- Backpressure: drop `o_ready` for 3 cycles at beat 0x22 of `0x44332211` -> `o=0x22`, `o_valid=1`, `o_last=0` held; the sequence then resumes with 0x33, 0x44.
- K=1, W=8: inputs 0xA0..0xA7 with `o_ready` pattern 1,0,1,1,0,0,1,1,... -> output order is exact; `i_ready` goes low only when two items are held; no loss and no duplication.
- `clk_en=0` for 2 cycles mid-item with `i_valid=1` and `o_ready=1` -> no beat advance, no accept, all outputs stable.
